switch_mem_resp: RTL and testbench
==================================

// Module: switch_mem_resp
//
// PURPOSE
// - Responder (switch-side) end of the mem config bus: mem_en/mem_rd_wr/mem_addr/mem_data.
// - Holds the four 8-bit output-port address registers and serves bus reads on mem_data.
// - Defers writes while a packet is in flight; flags bad configs; drives the one-hot port match used by the router.
//
// PARAMETERS
// - NUM_PORTS   4   output ports = config registers; fixed by the 2-bit mem_addr
// - DATA_W      8   register / mem_data / pkt_da width
//
// PORTS
// - clock       in     1         single clock; all inputs sampled at posedge clock
// - reset       in     1         synchronous, active-high
// - mem_en      in     1         bus access strobe, one access per high cycle
// - mem_rd_wr   in     1         1 = write, 0 = read
// - mem_addr    in     2         register index 0..3
// - mem_data    inout  8         write data in; read data driven out
// - pkt_busy    in     1         router mid-packet; config writes must not commit
// - pkt_da      in     8         destination address of current packet
// - port_match  out    4         one-hot: bit i set when pkt_da == reg[i] and cfg_valid
// - cfg_valid   out    1         all 4 regs written since reset and pairwise distinct
// - cfg_dup     out    1         two or more written regs hold equal values
// - wr_drop     out    1         1-cycle pulse: write discarded (pending slot full)
//
// BEHAVIOUR
// - Reset (sync, active-high): regs=8'h00, written mask=0, pending empty, read output disabled.
//   All outputs 0; mem_data released (Z). Reset mid-access aborts the access; nothing commits.
// - Write, pkt_busy=0: reg[mem_addr] <= mem_data at the strobe edge; visible the next cycle.
// - Write, pkt_busy=1, pending empty: {addr,data} captured into the 1-deep pending slot.
// - Write, pkt_busy=1, pending full: write discarded; wr_drop pulses the next cycle.
//   Pending contents are unchanged.
// - Pending commit: first edge with pkt_busy=0 and pending full.
//   - A new write arriving on that same edge also commits.
//   - Same address: the new write wins.
// - Read: accepted at the strobe edge. In the following cycle, mem_data = reg[mem_addr].
//   - Drive enable is high for exactly that one cycle, then Z.
//   - Latency 1. Back-to-back reads drive on consecutive cycles.
//   - Reads return committed values, never pending data.
// - Write-enable vs read: the switch never drives mem_data during a write cycle.
// - Config state machine (state register; cfg_valid, cfg_dup registered from it):
//   - UNCONFIG: mask==0. Any commit -> PARTIAL.
//   - PARTIAL: 0 < mask < 4'hF. Mask becomes 4'hF -> CHECK.
//   - CHECK: one cycle; compare all 6 pairs. Distinct -> CONFIGURED, else -> DUPLICATE.
//   - CONFIGURED: cfg_valid=1. Any commit -> CHECK; cfg_valid drops the next cycle.
//   - DUPLICATE: cfg_dup=1. Any commit -> CHECK.
//   - cfg_dup is also 1 in PARTIAL when written regs collide.
// - port_match: combinational compare of pkt_da against the 4 regs, gated by cfg_valid.
//   At most one bit is set, guaranteed by distinctness. All 0 when cfg_valid=0.
// - Widths: addr 2 b, no wrap logic needed. All 4 index values are legal.
//
// STRUCTURE
// - Package switch_cfg_pkg:
//   - NUM_PORTS, DATA_W
//   - typedef logic [1:0] cfg_addr_t
//   - typedef logic [7:0] cfg_data_t
//   - typedef enum {UNCONFIG, PARTIAL, CHECK, CONFIGURED, DUPLICATE} cfg_state_e
//   - MEM_WRITE = 1'b1, MEM_READ = 1'b0
// - Sub-module switch_cfg_match: reg array + pkt_da -> port_match one-hot and pairwise-dup flag.
// - Top holds the bus decode, pending slot, read driver and state machine.
// - mem_data driven via assign mem_data = rd_oe ? rd_q : 'z.
//
// TESTING
// 1. Reset, write 8'h11/22/33/44 to addr 0..3 with pkt_busy=0.
//    -> cfg_valid=1 two cycles after the last write; port_match=4'b0100 for pkt_da=8'h33.
// 2. Read addr 2 after test 1 -> mem_data=8'h33 exactly one cycle after the strobe, Z otherwise.
// 3. pkt_busy=1, write addr0=8'hAA then addr1=8'hBB:
//    - Read addr0 returns 8'h11.
//    - wr_drop pulses once, on the second write.
//    - Drop pkt_busy -> reg0=8'hAA, reg1=8'h22.
// 4. Write reg3=8'h11 over the valid config -> cfg_valid 0, cfg_dup 1; port_match=0 for pkt_da=8'h11.
// 5. Pending addr1=8'h55; on the pkt_busy fall edge also write addr1=8'h66 -> reg1 reads 8'h66.
// 6. Assert reset during a read strobe -> no drive next cycle, all regs 0, state UNCONFIG.

Source files
------------

// File: rtl/switch_cfg_pkg.sv
// Shared types for the switch config bus responder: register/address widths, FSM states, bus opcodes.
package switch_cfg_pkg;

  localparam int NUM_PORTS = 4;
  localparam int DATA_W    = 8;

  typedef logic [1:0]        cfg_addr_t;
  typedef logic [DATA_W-1:0] cfg_data_t;
  typedef cfg_data_t [NUM_PORTS-1:0] cfg_regs_t;

  typedef enum logic [2:0] {
    UNCONFIG,
    PARTIAL,
    CHECK,
    CONFIGURED,
    DUPLICATE
  } cfg_state_e;

  localparam logic MEM_WRITE = 1'b1;
  localparam logic MEM_READ  = 1'b0;

endpackage

// File: rtl/switch_mem_resp_if.sv
// Config bus strobes plus the router-facing match/status signals.
// mem_data stays a plain inout on the responder because it is bidirectional.
interface switch_mem_resp_if;
  import switch_cfg_pkg::*;

  logic                 mem_en;
  logic                 mem_rd_wr;
  cfg_addr_t            mem_addr;
  logic                 pkt_busy;
  cfg_data_t            pkt_da;
  logic [NUM_PORTS-1:0] port_match;
  logic                 cfg_valid;
  logic                 cfg_dup;
  logic                 wr_drop;

  modport master (
    output mem_en, mem_rd_wr, mem_addr, pkt_busy, pkt_da,
    input  port_match, cfg_valid, cfg_dup, wr_drop
  );

  modport slave (
    input  mem_en, mem_rd_wr, mem_addr, pkt_busy, pkt_da,
    output port_match, cfg_valid, cfg_dup, wr_drop
  );

endinterface

// File: rtl/switch_cfg_match.sv
// Port-address compare: one-hot match of pkt_da against the regs, and a duplicate flag over written regs.
// Purely combinational; no backpressure.
module switch_cfg_match
  import switch_cfg_pkg::*;
(
  input  cfg_regs_t            regs,
  input  logic [NUM_PORTS-1:0] written,
  input  cfg_data_t            pkt_da,
  input  logic                 match_en,
  output logic [NUM_PORTS-1:0] port_match,
  output logic                 dup
);

  always_comb begin
    port_match = '0;
    dup        = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      port_match[i] = match_en && (regs[i] == pkt_da);
      for (int j = i + 1; j < NUM_PORTS; j++) begin
        if (written[i] && written[j] && (regs[i] == regs[j]))
          dup = 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_mem_resp.sv
// Switch-side responder of the mem config bus: holds port address regs, defers writes mid-packet.
// Reads return data one cycle after the strobe; a second write while one is deferred is dropped.
module switch_mem_resp
  import switch_cfg_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  switch_mem_resp_if.slave      bus,
  inout  wire  [DATA_W-1:0]     mem_data
);

  logic                 wr_stb, rd_stb;
  cfg_regs_t            regs, regs_nxt;
  logic [NUM_PORTS-1:0] mask, mask_nxt;
  logic                 commit_any;
  logic                 pend_vld;
  cfg_addr_t            pend_addr;
  cfg_data_t            pend_dat;
  logic                 rd_oe;
  cfg_data_t            rd_q;
  logic                 wr_drop_q;
  logic                 regs_dup;
  logic [NUM_PORTS-1:0] match_vec;
  cfg_state_e           state_q, state_nxt;

  assign wr_stb = bus.mem_en && (bus.mem_rd_wr == MEM_WRITE);
  assign rd_stb = bus.mem_en && (bus.mem_rd_wr == MEM_READ);

  assign mem_data = rd_oe ? rd_q : 'z;

  // Deferred write goes first so a write arriving on the same edge overrides it.
  always_comb begin
    regs_nxt   = regs;
    mask_nxt   = mask;
    commit_any = 1'b0;
    if (!bus.pkt_busy) begin
      if (pend_vld) begin
        regs_nxt[pend_addr] = pend_dat;
        mask_nxt[pend_addr] = 1'b1;
        commit_any          = 1'b1;
      end
      if (wr_stb) begin
        regs_nxt[bus.mem_addr] = mem_data;
        mask_nxt[bus.mem_addr] = 1'b1;
        commit_any             = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      regs      <= '0;
      mask      <= '0;
      pend_vld  <= 1'b0;
      pend_addr <= '0;
      pend_dat  <= '0;
      rd_oe     <= 1'b0;
      rd_q      <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      regs      <= regs_nxt;
      mask      <= mask_nxt;
      rd_oe     <= rd_stb;
      rd_q      <= regs[bus.mem_addr];
      wr_drop_q <= bus.pkt_busy && wr_stb && pend_vld;
      if (!bus.pkt_busy) begin
        pend_vld <= 1'b0;
      end else if (wr_stb && !pend_vld) begin
        pend_vld  <= 1'b1;
        pend_addr <= bus.mem_addr;
        pend_dat  <= mem_data;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= UNCONFIG;
    else       state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      UNCONFIG, PARTIAL: begin
        if (mask_nxt == '1)      state_nxt = CHECK;
        else if (mask_nxt != '0) state_nxt = PARTIAL;
      end
      // A commit during the check cycle changes the regs, so check again.
      CHECK: begin
        if (commit_any)    state_nxt = CHECK;
        else if (regs_dup) state_nxt = DUPLICATE;
        else               state_nxt = CONFIGURED;
      end
      CONFIGURED, DUPLICATE: begin
        if (commit_any) state_nxt = CHECK;
      end
      default: state_nxt = UNCONFIG;
    endcase
  end

  assign bus.cfg_valid = (state_q == CONFIGURED);
  assign bus.cfg_dup   = (state_q == DUPLICATE) || ((state_q == PARTIAL) && regs_dup);
  assign bus.wr_drop   = wr_drop_q;

  switch_cfg_match u_match (
    .regs       (regs),
    .written    (mask),
    .pkt_da     (bus.pkt_da),
    .match_en   (bus.cfg_valid),
    .port_match (match_vec),
    .dup        (regs_dup)
  );

  assign bus.port_match = match_vec;

endmodule

// File: tb/tb_switch_mem_resp.sv
// Scoreboard bench: reads push expected data, a negedge monitor pops on each responder drive.
module tb_switch_mem_resp;

  typedef struct {
    int unsigned cyc;
    logic [7:0]  d;
  } rd_exp_t;

  logic        clk;
  logic        reset;
  logic [7:0]  tb_drv;
  logic        tb_drv_en;
  wire  [7:0]  mem_data;
  int unsigned cyc_n;
  int          tests;
  int          fails;
  logic [7:0]  da_v;

  rd_exp_t     exp_q[$];

  logic [7:0]  m_reg[4];
  logic [3:0]  m_mask;
  bit          m_pend;
  logic [1:0]  m_pa;
  logic [7:0]  m_pd;
  bit          m_checking;

  switch_mem_resp_if bus();

  assign mem_data = tb_drv_en ? tb_drv : 8'hzz;

  switch_mem_resp dut (
    .clock    (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .mem_data (mem_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc_n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    rd_exp_t e;
    if (dut.rd_oe) begin
      if (exp_q.size() == 0) begin
        chk("spurious_drive", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rd_latency", cyc_n, e.cyc + 1);
        chk("rd_data", {24'd0, mem_data}, {24'd0, e.d});
      end
    end else if (exp_q.size() > 0 && exp_q[0].cyc + 1 < cyc_n) begin
      e = exp_q.pop_front();
      chk("rd_missing", 32'd0, 32'd1);
    end
  end

  function automatic bit collide();
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++)
        if (m_mask[i] && m_mask[j] && m_reg[i] == m_reg[j]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic cyc(input bit en, input bit rw, input logic [1:0] a, input logic [7:0] d,
                     input bit busy, input bit rst);
    bit wr, rd, exp_drop, commit, ev, ed;
    logic [3:0] exp_pm;
    reset         = rst;
    bus.mem_en    = en;
    bus.mem_rd_wr = rw;
    bus.mem_addr  = a;
    bus.pkt_busy  = busy;
    bus.pkt_da    = da_v;
    tb_drv        = d;
    tb_drv_en     = en && rw;
    wr = en && rw && !rst;
    rd = en && !rw && !rst;
    if (rd) exp_q.push_back('{cyc_n, m_reg[a]});
    exp_drop = wr && busy && m_pend;
    @(posedge clk);
    #1;
    commit = 1'b0;
    if (rst) begin
      for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
      m_mask = 4'h0;
      m_pend = 1'b0;
    end else if (!busy) begin
      if (m_pend) begin
        m_reg[m_pa] = m_pd;
        m_mask[m_pa] = 1'b1;
        commit = 1'b1;
      end
      if (wr) begin
        m_reg[a] = d;
        m_mask[a] = 1'b1;
        commit = 1'b1;
      end
      m_pend = 1'b0;
    end else if (wr && !m_pend) begin
      m_pend = 1'b1;
      m_pa   = a;
      m_pd   = d;
    end
    // A full register set is judged one cycle after the commit that completes or changes it.
    m_checking = commit && (m_mask == 4'hF);
    if (m_mask == 4'h0)      begin ev = 1'b0; ed = 1'b0; end
    else if (m_mask != 4'hF) begin ev = 1'b0; ed = collide(); end
    else if (m_checking)     begin ev = 1'b0; ed = 1'b0; end
    else                     begin ev = !collide(); ed = collide(); end
    for (int i = 0; i < 4; i++) exp_pm[i] = ev && (m_reg[i] == da_v);
    chk("wr_drop", {31'd0, bus.wr_drop}, {31'd0, exp_drop});
    chk("cfg_valid", {31'd0, bus.cfg_valid}, {31'd0, ev});
    chk("cfg_dup", {31'd0, bus.cfg_dup}, {31'd0, ed});
    chk("port_match", {28'd0, bus.port_match}, {28'd0, exp_pm});
    bus.mem_en = 1'b0;
    tb_drv_en  = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d, input bit busy);
    cyc(1'b1, 1'b1, a, d, busy, 1'b0);
  endtask

  task automatic rd(input logic [1:0] a, input bit busy);
    cyc(1'b1, 1'b0, a, 8'h00, busy, 1'b0);
  endtask

  task automatic idle(input bit busy);
    cyc(1'b0, 1'b0, 2'd0, 8'h00, busy, 1'b0);
  endtask

  initial begin
    bit busy, prev_rd, rst;
    int unsigned r;
    tests = 0;
    fails = 0;
    cyc_n = 0;
    da_v = 8'h00;
    reset = 1'b1;
    tb_drv = 8'h00;
    tb_drv_en = 1'b0;
    bus.mem_en = 1'b0;
    bus.mem_rd_wr = 1'b0;
    bus.mem_addr = 2'd0;
    bus.pkt_busy = 1'b0;
    bus.pkt_da = 8'h00;
    for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
    m_mask = 4'h0;
    m_pend = 1'b0;
    m_pa = 2'd0;
    m_pd = 8'h00;
    m_checking = 1'b0;
    @(posedge clk);
    #1;
    cyc(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1);

    // Basic configuration, then match on 0x33.
    wr(2'd0, 8'h11, 1'b0);
    wr(2'd1, 8'h22, 1'b0);
    wr(2'd2, 8'h33, 1'b0);
    wr(2'd3, 8'h44, 1'b0);
    da_v = 8'h33;
    idle(1'b0);
    chk("t1_port_match", {28'd0, bus.port_match}, 32'h4);
    rd(2'd2, 1'b0);
    idle(1'b0);
    idle(1'b0);

    // Deferred write, dropped second write, commit on busy release.
    wr(2'd0, 8'hAA, 1'b1);
    rd(2'd0, 1'b1);
    idle(1'b1);
    wr(2'd1, 8'hBB, 1'b1);
    idle(1'b1);
    idle(1'b0);
    rd(2'd0, 1'b0);
    rd(2'd1, 1'b0);
    idle(1'b0);

    // Restore reg0, then collide reg3 with it.
    wr(2'd0, 8'h11, 1'b0);
    idle(1'b0);
    da_v = 8'h11;
    wr(2'd3, 8'h11, 1'b0);
    idle(1'b0);
    idle(1'b0);
    chk("t4_cfg_dup", {31'd0, bus.cfg_dup}, 32'd1);

    // Pending write overridden by a same-address write on the release edge.
    wr(2'd1, 8'h55, 1'b1);
    idle(1'b1);
    wr(2'd1, 8'h66, 1'b0);
    idle(1'b0);
    rd(2'd1, 1'b0);
    idle(1'b0);

    // Reset on a read strobe aborts the read.
    cyc(1'b1, 1'b0, 2'd2, 8'h00, 1'b0, 1'b1);
    idle(1'b0);
    for (int i = 0; i < 4; i++) rd(i[1:0], 1'b0);
    idle(1'b0);

    busy = 1'b0;
    prev_rd = 1'b0;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 99) < 20) busy = !busy;
      da_v = 8'($urandom_range(0, 7));
      rst = ($urandom_range(0, 199) == 0);
      r = $urandom_range(0, 99);
      if (r < 45 && !prev_rd) begin
        cyc(1'b1, 1'b1, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 7)), busy, rst);
        prev_rd = 1'b0;
      end else if (r < 75) begin
        cyc(1'b1, 1'b0, 2'($urandom_range(0, 3)), 8'h00, busy, rst);
        prev_rd = !rst;
      end else begin
        cyc(1'b0, 1'b0, 2'd0, 8'h00, busy, rst);
        prev_rd = 1'b0;
      end
    end
    idle(1'b0);
    idle(1'b0);
    idle(1'b0);
    chk("rd_queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
